multicycle_main_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and writeback states.
- Drives the 2-bit alu_op consumed by the ALU-control decoder: 00 = add, 01 = subtract, 10 = use func field.
- Also drives all datapath enables and mux selects, and stalls on memory with a ready handshake.

---
 rtl/multicycle_main_control.sv | 267 ++++++++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// multicycle_main_control
// Main control FSM for the multicycle MIPS datapath. It sequences the
// fetch, decode, execute, memory and writeback steps. It drives every
// datapath enable and mux select, and produces the 2-bit alu_op that the
// ALU-control decoder consumes.
//
// The FSM is Moore style: outputs decode from the state register only.
// The exception is FETCH, where mem_ready qualifies ir_write and pc_write,
// so the instruction register and PC load only when the fetch completes.
//
// Optional feature, enabled by defining the macro BNE_SUPPORT_EN:
//   - adds the bne opcode (000101) and the BNEQ state (encoding 12);
//   - adds the branch_ne output, a PC load qualified by !zero.
// When the macro is undefined, 000101 decodes as an illegal opcode and the
// branch_ne port does not exist.
module multicycle_main_control #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         OPCODE_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                branch,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_op,
  output logic                illegal_op,
`ifdef BNE_SUPPORT_EN
  output logic                branch_ne,
`endif
  output logic [3:0]          state_o
);

  // State encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
`ifdef BNE_SUPPORT_EN
  localparam logic [3:0] S_BNEQ     = 4'd12;
`endif

  // Opcode values (instr[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
`ifdef BNE_SUPPORT_EN
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
`endif

  // ALU operation codes for the ALU-control decoder
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SEXT2 = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  logic [3:0] r_state;
  logic       r_illegal;
  logic [3:0] w_next_state;
  logic       w_illegal_next;

  // State register and the one-cycle illegal-opcode flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RESET_STATE;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_illegal <= w_illegal_next;
    end
  end

  // Next-state decode; opcode is consulted only in DECODE and MEMADR
  always_comb begin
    w_next_state   = S_FETCH;
    w_illegal_next = 1'b0;
    case (r_state)
      S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW,
          OP_SW:    w_next_state = S_MEMADR;
          OP_RTYPE: w_next_state = S_EXECUTE;
          OP_BEQ:   w_next_state = S_BRANCH;
          OP_ADDI:  w_next_state = S_ADDIEX;
          OP_J:     w_next_state = S_JUMP;
`ifdef BNE_SUPPORT_EN
          OP_BNE:   w_next_state = S_BNEQ;
`endif
          default: begin
            w_next_state   = S_FETCH;
            w_illegal_next = 1'b1;
          end
        endcase
      end
      // If the opcode changed to a non-memory value after DECODE, this
      // abandons the instruction quietly instead of guessing an access.
      S_MEMADR: begin
        if (opcode == OP_LW)
          w_next_state = S_MEMREAD;
        else if (opcode == OP_SW)
          w_next_state = S_MEMWRITE;
        else
          w_next_state = S_FETCH;
      end
      S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_ADDIEX:   w_next_state = S_ADDIWB;
      S_ADDIWB:   w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
`ifdef BNE_SUPPORT_EN
      S_BNEQ:     w_next_state = S_FETCH;
`endif
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Output decode from state; all write enables are held low while reset is high
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
`ifdef BNE_SUPPORT_EN
    branch_ne  = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        iord      = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        pc_src    = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 1'b0;
        alu_src_b = SRCB_SEXT2;
        alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
`ifdef BNE_SUPPORT_EN
      S_BNEQ: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_SUB;
        branch_ne = 1'b1;
        pc_src    = PCSRC_ALUOUT;
      end
`endif
      default: begin
        pc_write = 1'b0;
      end
    endcase
    // Reset overrides the enables combinationally so nothing is written
    // even before the first clock edge has loaded the state register.
    if (reset) begin
      pc_write  = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
`ifdef BNE_SUPPORT_EN
      branch_ne = 1'b0;
`endif
    end
  end

  assign state_o    = r_state;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed testbench for multicycle_main_control.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic [3:0] state_o;
`ifdef BNE_SUPPORT_EN
  logic       branch_ne;
`endif
  logic [5:0] en;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign en = {pc_write, branch, ir_write, reg_write, mem_write, mem_read};

  multicycle_main_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
`ifdef BNE_SUPPORT_EN
    .branch_ne  (branch_ne),
`endif
    .state_o    (state_o)
  );

  // Reset before the first edge, then reset asserted mid-MEMREAD for 3 cycles
  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b100011;
    #1;
    n_checks++;
    if (en !== 6'b0) $display("FAIL reset_pre_edge_en: got %b want 000000", en); else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (state_o !== 4'd0) $display("FAIL reset_state: got %0d want 0", state_o); else n_pass++;
    n_checks++;
    if (illegal_op !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal_op); else n_pass++;
    reset = 1'b0; #1;
    n_checks++;
    if (ir_write !== 1'b1) $display("FAIL fetch_ir_write_after_reset: got %b want 1", ir_write); else n_pass++;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if (state_o !== 4'd3) $display("FAIL reach_memread: got %0d want 3", state_o); else n_pass++;
    mem_ready = 1'b0; reset = 1'b1; #1;
    n_checks++;
    if (en !== 6'b0) $display("FAIL reset_memread_en: got %b want 000000", en); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (state_o !== 4'd0) $display("FAIL reset_hold_state[%0d]: got %0d want 0", i, state_o); else n_pass++;
      n_checks++;
      if (en !== 6'b0) $display("FAIL reset_hold_en[%0d]: got %b want 000000", i, en); else n_pass++;
    end
    reset = 1'b0; mem_ready = 1'b0; #1;
    n_checks++;
    if (state_o !== 4'd0 || reg_write !== 1'b0)
      $display("FAIL reset_release: got state %0d reg_write %b want state 0 reg_write 0", state_o, reg_write);
    else n_pass++;
  endtask

  // R-type: 0,1,6,7,0
  task automatic test_rtype();
    logic [3:0] exp_s [5];
    exp_s = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if (state_o !== exp_s[i]) $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (alu_op !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00)
          $display("FAIL rtype_execute: got alu_op %b srca %b srcb %b want 10 1 00", alu_op, alu_src_a, alu_src_b);
        else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0)
          $display("FAIL rtype_aluwb: got reg_write %b reg_dst %b m2r %b want 1 1 0", reg_write, reg_dst, mem_to_reg);
        else n_pass++;
      end
    end
  endtask

  // lw with two wait cycles in MEMREAD: 0,1,2,3,3,3,4,0
  task automatic test_lw_wait();
    logic [3:0] exp_s [8];
    logic       rdy [8];
    exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    rdy   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (state_o !== exp_s[i]) $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); else n_pass++;
      if (i >= 3 && i <= 5) begin
        n_checks++;
        if (iord !== 1'b1 || mem_read !== 1'b1 || reg_write !== 1'b0)
          $display("FAIL lw_memread[%0d]: got iord %b mem_read %b reg_write %b want 1 1 0", i, iord, mem_read, reg_write);
        else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0)
          $display("FAIL lw_memwb: got reg_write %b m2r %b reg_dst %b want 1 1 0", reg_write, mem_to_reg, reg_dst);
        else n_pass++;
      end
    end
  endtask

  // FETCH stalled 4 cycles, then j: 0,0,0,0,0,1,11,0
  task automatic test_fetch_stall_jump();
    logic [3:0] exp_s [8];
    logic       rdy [8];
    exp_s = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd11, 4'd0};
    rdy   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 6'b000010;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (state_o !== exp_s[i]) $display("FAIL stall_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); else n_pass++;
      if (i < 4) begin
        n_checks++;
        if (ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1)
          $display("FAIL stall_en[%0d]: got ir_write %b pc_write %b mem_read %b want 0 0 1", i, ir_write, pc_write, mem_read);
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1)
          $display("FAIL stall_ready_pulse: got ir_write %b pc_write %b want 1 1", ir_write, pc_write);
        else n_pass++;
      end
      if (i == 5) begin
        n_checks++;
        if (ir_write !== 1'b0) $display("FAIL stall_single_pulse: got ir_write %b want 0", ir_write); else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if (pc_write !== 1'b1 || pc_src !== 2'b10)
          $display("FAIL jump_outputs: got pc_write %b pc_src %b want 1 10", pc_write, pc_src);
        else n_pass++;
      end
    end
  endtask

  // beq: 0,1,8,0
  task automatic test_beq();
    logic [3:0] exp_s [4];
    exp_s = '{4'd0, 4'd1, 4'd8, 4'd0};
    opcode = 6'b000100; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if (state_o !== exp_s[i]) $display("FAIL beq_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (alu_op !== 2'b01 || branch !== 1'b1 || pc_src !== 2'b01 || pc_write !== 1'b0)
          $display("FAIL beq_outputs: got alu_op %b branch %b pc_src %b pc_write %b want 01 1 01 0", alu_op, branch, pc_src, pc_write);
        else n_pass++;
      end
    end
  endtask

  // Back-to-back sw then addi with mem_ready high: 0,1,2,5,0 then 1,9,10,0
  task automatic test_back_to_back();
    logic [3:0] exp_s [9];
    exp_s = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      opcode = (i < 4) ? 6'b101011 : 6'b001000;
      #1;
      n_checks++;
      if (state_o !== exp_s[i]) $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (mem_write !== 1'b1 || iord !== 1'b1 || mem_read !== 1'b0)
          $display("FAIL sw_memwrite: got mem_write %b iord %b mem_read %b want 1 1 0", mem_write, iord, mem_read);
        else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 2'b00)
          $display("FAIL addi_ex: got srca %b srcb %b alu_op %b want 1 10 00", alu_src_a, alu_src_b, alu_op);
        else n_pass++;
      end
      if (i == 7) begin
        n_checks++;
        if (reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0)
          $display("FAIL addi_wb: got reg_write %b reg_dst %b m2r %b want 1 0 0", reg_write, reg_dst, mem_to_reg);
        else n_pass++;
      end
    end
  endtask

  // Unknown opcode: 0,1,0,0 with illegal_op high only in the third cycle
  task automatic test_illegal(input logic [5:0] op, input string tag);
    logic [3:0] exp_s [4];
    logic       rdy [4];
    logic       exp_ill [4];
    exp_s   = '{4'd0, 4'd1, 4'd0, 4'd0};
    rdy     = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_ill = '{1'b0, 1'b0, 1'b1, 1'b0};
    opcode = op;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (state_o !== exp_s[i]) $display("FAIL %s_state[%0d]: got %0d want %0d", tag, i, state_o, exp_s[i]); else n_pass++;
      n_checks++;
      if (illegal_op !== exp_ill[i]) $display("FAIL %s_illegal[%0d]: got %b want %b", tag, i, illegal_op, exp_ill[i]); else n_pass++;
    end
  endtask

`ifdef BNE_SUPPORT_EN
  // bne: 0,1,12,0 with branch_ne in state 12
  task automatic test_bne();
    logic [3:0] exp_s [4];
    exp_s = '{4'd0, 4'd1, 4'd12, 4'd0};
    opcode = 6'b000101; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if (state_o !== exp_s[i]) $display("FAIL bne_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (branch_ne !== 1'b1 || branch !== 1'b0 || alu_op !== 2'b01 || pc_src !== 2'b01 || illegal_op !== 1'b0)
          $display("FAIL bne_outputs: got bne %b branch %b alu_op %b pc_src %b ill %b want 1 0 01 01 0",
                   branch_ne, branch, alu_op, pc_src, illegal_op);
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_fetch_stall_jump();
    test_beq();
    test_back_to_back();
    test_illegal(6'b111111, "illegal_ff");
`ifdef BNE_SUPPORT_EN
    test_bne();
`else
    test_illegal(6'b000101, "bne_disabled");
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
